// File: rtl/hs_pkg.sv
// Shared definitions for the clocked 4-phase handshake terminators.
package hs_pkg;

  // Consumer-side handshake FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    ACK_HI = 2'd2
  } hs_state_t;

  // Default synchroniser depth for request inputs crossing into clk.
  localparam int HS_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/hs_sync.sv
// Flop-chain synchroniser for a single asynchronous level.
// STAGES must be at least 2; the output is the last stage only.
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; clear on reset.
  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/hs4_sync_sink.sv
// Terminates a 4-phase return-to-zero request/acknowledge channel and
// presents each bundled token on a valid/ready interface.
//
//   state  | meaning
//   -------+-------------------------------------------------------
//   IDLE   | no token held; waiting for synchronised request high
//   VALID  | token captured, out_valid high, waiting for out_ready
//   ACK_HI | a_out high, waiting for synchronised request low
module hs4_sync_sink
  import hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = HS_SYNC_STAGES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r_in,
  input  logic [DATA_W-1:0] d_in,
  output logic              a_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  token_cnt,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_s;
  hs_state_t         state_q, state_d;
  logic              ack_entry_q;
  logic              a_out_d;
  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_d;

  hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (r_in),
    .q     (r_s)
  );

  // State and registered outputs; ack_entry_q marks the first ACK_HI cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_entry_q <= 1'b0;
      a_out       <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      token_cnt   <= '0;
      proto_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_entry_q <= (state_d == ACK_HI) && (state_q != ACK_HI);
      a_out       <= a_out_d;
      out_valid   <= valid_d;
      out_data    <= data_d;
      token_cnt   <= cnt_d;
      proto_err   <= err_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    a_out_d = a_out;
    valid_d = out_valid;
    data_d  = out_data;
    cnt_d   = token_cnt;
    err_d   = proto_err;

    case (state_q)
      IDLE: begin
        a_out_d = 1'b0;
        valid_d = 1'b0;
        if (r_s) begin
          data_d  = d_in;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end

      VALID: begin
        valid_d = 1'b1;
        // Request withdrawn before acknowledge: flag it, but the data is
        // already captured so the transfer still completes.
        if (!r_s) err_d = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          a_out_d = 1'b1;
          if (token_cnt != CNT_MAX) cnt_d = token_cnt + CNT_W'(1);
          state_d = ACK_HI;
        end
      end

      ACK_HI: begin
        a_out_d = 1'b1;
        // Request already low on entry means a_out only pulses one cycle.
        if (ack_entry_q && !r_s) err_d = 1'b1;
        if (!r_s) begin
          a_out_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        a_out_d = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hs4_sync_sink.sv
// Self-checking bench for hs4_sync_sink. A second instance with CNT_W=3
// shares all inputs and is used to check counter saturation.
module tb_hs4_sync_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       r_in;
  logic [7:0] d_in;
  logic       out_ready;
  logic       a_out, out_valid, proto_err;
  logic [7:0] out_data;
  logic [15:0] token_cnt;
  logic       a_out_s, out_valid_s, proto_err_s;
  logic [7:0] out_data_s;
  logic [2:0] token_cnt_s;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int exp_sat = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  hs4_sync_sink #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .r_in(r_in), .d_in(d_in), .a_out(a_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .token_cnt(token_cnt), .proto_err(proto_err)
  );

  hs4_sync_sink #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .r_in(r_in), .d_in(d_in), .a_out(a_out_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .token_cnt(token_cnt_s), .proto_err(proto_err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a_out (which=0) or out_valid (which=1) to reach lvl.
  task automatic wait_out(input int which, input logic lvl, input string tag);
    int n = 0;
    while (((which == 0) ? a_out : out_valid) !== lvl && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk(tag, 32'd0, 32'd1);
  endtask

  // Full upstream 4-phase cycle with out_ready held high.
  task automatic send(input logic [7:0] data);
    out_ready = 1'b1;
    d_in = data;
    r_in = 1'b1;
    sb_q.push_back(data);
    wait_out(0, 1'b1, "timeout_ack_hi");
    r_in = 1'b0;
    wait_out(0, 1'b0, "timeout_ack_lo");
    exp_cnt++;
    if (exp_sat < 7) exp_sat++;
  endtask

  // Scoreboard: every accepted token must match the oldest one driven.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, out_data}, {24'd0, sb_q.pop_front()});
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; r_in = 1'b0; d_in = 8'h00; out_ready = 1'b0;
    repeat (5) tick();
    chk("rst_a_out", {31'd0, a_out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", {16'd0, token_cnt}, 32'd0);
    chk("rst_err", {31'd0, proto_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Single token with exact latencies.
    d_in = 8'hA5; r_in = 1'b1; out_ready = 1'b1;
    sb_q.push_back(8'hA5);
    tick(); tick();
    chk("lat_valid_e2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {24'd0, out_data}, 32'hA5);
    chk("lat_ack_e3", {31'd0, a_out}, 32'd0);
    tick();
    chk("lat_ack_e4", {31'd0, a_out}, 32'd1);
    chk("lat_valid_e4", {31'd0, out_valid}, 32'd0);
    r_in = 1'b0;
    tick(); tick();
    chk("lat_acklo_e2", {31'd0, a_out}, 32'd1);
    tick();
    chk("lat_acklo_e3", {31'd0, a_out}, 32'd0);
    exp_cnt = 1; exp_sat = 1;
    chk("single_cnt", {16'd0, token_cnt}, exp_cnt);
    chk("single_err", {31'd0, proto_err}, 32'd0);
    tick();

    // Backpressure: token held stable while out_ready is low.
    out_ready = 1'b0; d_in = 8'h3C; r_in = 1'b1;
    sb_q.push_back(8'h3C);
    wait_out(1, 1'b1, "timeout_bp_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {24'd0, out_data}, 32'h3C);
      chk("bp_ack", {31'd0, a_out}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ack_rise", {31'd0, a_out}, 32'd1);
    r_in = 1'b0;
    wait_out(0, 1'b0, "timeout_bp_acklo");
    exp_cnt++; exp_sat++;
    chk("bp_cnt", {16'd0, token_cnt}, exp_cnt);

    // Merge-like traffic: alternating sources, 4 tokens each.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = (i % 2 == 0) ? (8'h10 + 8'(i)) : (8'hE0 + 8'(i));
      send(v);
    end
    chk("merge_cnt", {16'd0, token_cnt}, exp_cnt);
    chk("merge_err", {31'd0, proto_err}, 32'd0);
    chk("merge_sb_left", sb_q.size(), 32'd0);

    // Early request release while VALID.
    out_ready = 1'b0; d_in = 8'h5A; r_in = 1'b1;
    sb_q.push_back(8'h5A);
    wait_out(1, 1'b1, "timeout_er_valid");
    r_in = 1'b0;
    tick(); tick();
    chk("er_err_e2", {31'd0, proto_err}, 32'd0);
    tick();
    chk("er_err_e3", {31'd0, proto_err}, 32'd1);
    chk("er_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("er_ack_pulse", {31'd0, a_out}, 32'd1);
    tick();
    chk("er_ack_drop", {31'd0, a_out}, 32'd0);
    exp_cnt++; exp_sat = (exp_sat < 7) ? exp_sat + 1 : 7;
    chk("er_cnt", {16'd0, token_cnt}, exp_cnt);
    chk("er_err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset while a token is pending in VALID with r_in still high.
    out_ready = 1'b0; d_in = 8'h77; r_in = 1'b1;
    sb_q.push_back(8'h77);
    wait_out(1, 1'b1, "timeout_rm_valid");
    d_in = 8'h88;
    reset = 1'b1;
    sb_q.delete();
    tick();
    chk("rm_ack", {31'd0, a_out}, 32'd0);
    chk("rm_valid", {31'd0, out_valid}, 32'd0);
    chk("rm_cnt", {16'd0, token_cnt}, 32'd0);
    chk("rm_err", {31'd0, proto_err}, 32'd0);
    chk("rm_sat_cnt", {29'd0, token_cnt_s}, 32'd0);
    reset = 1'b0;
    exp_cnt = 0; exp_sat = 0;
    sb_q.push_back(8'h88);
    tick(); tick();
    chk("rm_valid_e2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rm_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("rm_data", {24'd0, out_data}, 32'h88);
    out_ready = 1'b1;
    wait_out(0, 1'b1, "timeout_rm_ack");
    r_in = 1'b0;
    wait_out(0, 1'b0, "timeout_rm_acklo");
    exp_cnt++; exp_sat++;
    chk("rm_cnt_after", {16'd0, token_cnt}, exp_cnt);

    // Saturation on the 3-bit counter instance.
    for (int i = 0; i < 10; i++) begin
      send(8'(8'hC0 + i));
      if (i == 5) chk("sat_cnt_mid", {29'd0, token_cnt_s}, exp_sat);
    end
    chk("sat_cnt", {29'd0, token_cnt_s}, 32'd7);
    chk("sat_exp", {29'd0, token_cnt_s}, exp_sat);
    chk("main_cnt_end", {16'd0, token_cnt}, exp_cnt);
    chk("end_err", {31'd0, proto_err}, 32'd0);
    chk("end_sb_left", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
